// File: rtl/hazard_scoreboard_if.sv
// ============================================================================
// Module   : hazard_scoreboard_if
// Brief    : ID-stage operand/destination bundle and interlock results.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface hazard_scoreboard_if #(
  parameter int REG_ADDR_W = 4,
  parameter int PERF_W     = 16
);
  logic                  id_valid;
  logic                  id_rd_en1;
  logic [REG_ADDR_W-1:0] id_src1;
  logic                  id_rd_en2;
  logic [REG_ADDR_W-1:0] id_src2;
  logic                  id_early;
  logic                  id_wr_en;
  logic [REG_ADDR_W-1:0] id_dst;
  logic                  id_is_load;
  logic                  flush;
  logic                  stall;
  logic [1:0]            hazard_src;
  logic [PERF_W-1:0]     stall_cnt;

  modport master (
    output id_valid, id_rd_en1, id_src1, id_rd_en2, id_src2, id_early,
           id_wr_en, id_dst, id_is_load, flush,
    input  stall, hazard_src, stall_cnt
  );

  modport slave (
    input  id_valid, id_rd_en1, id_src1, id_rd_en2, id_src2, id_early,
           id_wr_en, id_dst, id_is_load, flush,
    output stall, hazard_src, stall_cnt
  );
endinterface

`default_nettype wire

// File: rtl/hazard_scoreboard.sv
// ============================================================================
// Module   : hazard_scoreboard
// Brief    : Per-register countdown scoreboard raising ID stalls on RAW hazards.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hazard_scoreboard #(
  parameter int REG_ADDR_W  = 4,
  parameter int LOAD_LAT    = 1,
  parameter int ALU_LAT     = 0,
  parameter int EARLY_EXTRA = 1,
  parameter int CNT_W       = 2,
  parameter bit ZERO_REG    = 1'b1,
  parameter int PERF_W      = 16
) (
  input  wire                 clk,
  input  wire                 rst_n,
  hazard_scoreboard_if.slave  bus
);
  localparam int             c_entries   = 2 ** REG_ADDR_W;
  localparam logic [CNT_W-1:0] c_load_init = CNT_W'(LOAD_LAT + EARLY_EXTRA);
  localparam logic [CNT_W-1:0] c_alu_init  = CNT_W'(ALU_LAT + EARLY_EXTRA);
  localparam logic [CNT_W-1:0] c_norm_thr  = CNT_W'(EARLY_EXTRA);

  logic [CNT_W-1:0]  r_cnt [c_entries];
  logic [PERF_W-1:0] r_stall_cnt;

  logic [CNT_W-1:0]  w_thr;
  logic              w_hit1;
  logic              w_hit2;
  logic              w_stall;
  logic              w_issue;
  logic [CNT_W-1:0]  w_init;

  // Normal consumers read from the EX forward path, so the extra early cycles
  // are already covered for them; early consumers need the counter fully drained.
  assign w_thr  = bus.id_early ? '0 : c_norm_thr;
  assign w_hit1 = bus.id_rd_en1 && !(ZERO_REG && (bus.id_src1 == '0)) &&
                  (r_cnt[bus.id_src1] > w_thr);
  assign w_hit2 = bus.id_rd_en2 && !(ZERO_REG && (bus.id_src2 == '0)) &&
                  (r_cnt[bus.id_src2] > w_thr);

  assign w_stall = bus.id_valid && !bus.flush && (w_hit1 || w_hit2);
  assign w_issue = bus.id_valid && !w_stall && !bus.flush && bus.id_wr_en &&
                   !(ZERO_REG && (bus.id_dst == '0));
  assign w_init  = bus.id_is_load ? c_load_init : c_alu_init;

  assign bus.stall      = w_stall;
  assign bus.hazard_src = w_stall ? {w_hit2, w_hit1} : 2'b00;
  assign bus.stall_cnt  = r_stall_cnt;

  // The hazard check above reads pre-issue state, so a load using its own
  // destination as base register never stalls on itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < c_entries; r++) begin
        r_cnt[r] <= '0;
      end
    end else begin
      for (int r = 0; r < c_entries; r++) begin
        if (bus.flush) begin
          r_cnt[r] <= '0;
        end else if (w_issue && (bus.id_dst == REG_ADDR_W'(r))) begin
          r_cnt[r] <= w_init;
        end else if (r_cnt[r] != '0) begin
          r_cnt[r] <= r_cnt[r] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end
endmodule

`default_nettype wire
